lcd_dma_fifo: RTL and testbench

LCD_DMA_FIFO -- requirements
Module: lcd_dma_fifo

---
 rtl/lcd_fifo_pkg.sv | 10 +
 rtl/lcd_dma_fifo.sv | 109 ++++++++++
 tb/lcd_fifo_ram.sv | 21 ++
 tb/tb_lcd_dma_fifo.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/lcd_fifo_pkg.sv
// rtl/lcd_fifo_pkg.sv - shared defaults and occupancy type for the LCD DMA FIFO
package lcd_fifo_pkg;

  localparam int LCD_FIFO_DW = 32;
  localparam int LCD_FIFO_AW = 5;

  // Occupancy needs one bit more than the address so that DEPTH itself is representable
  typedef logic [LCD_FIFO_AW:0] lcd_fifo_cnt_t;

endpackage

// File: rtl/lcd_dma_fifo.sv
// rtl/lcd_dma_fifo.sv - pixel-word FIFO between the AHB fetch master and the LCD serialiser
// Storage is an external dual-port RAM with one-cycle synchronous read.
module lcd_dma_fifo
  import lcd_fifo_pkg::*;
#(
  parameter int DATA_W = LCD_FIFO_DW,
  parameter int ADDR_W = LCD_FIFO_AW
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W:0]   watermark,
  output logic              dma_req,
  output logic [ADDR_W:0]   count,
  output logic              underflow,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              underflow_q, underflow_d;
  logic              dma_req_q, dma_req_d;
  logic              full, push_ok, pop_ok;

  // Accept decisions use registered occupancy only, so a pop never frees space for a same-cycle push
  always_comb begin
    full    = (count_q == FULL_CNT);
    push_ok = wr_valid && !full && !flush;
    pop_ok  = rd_req && (count_q != '0) && !flush;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    underflow_d = underflow_q;
    dma_req_d   = dma_req_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
      dma_req_d   = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      rd_valid_d = pop_ok;
      if (rd_req && (count_q == '0)) underflow_d = 1'b1;
      // Hysteresis: request from the watermark down, keep requesting until completely full
      if (full) begin
        dma_req_d = 1'b0;
      end else if (count_q <= watermark) begin
        dma_req_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      dma_req_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
      dma_req_q   <= dma_req_d;
    end
  end

  assign wr_ready  = !full;
  assign mem_write = push_ok;
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = wr_data;
  assign mem_raddr = rd_ptr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = mem_rdata;
  assign count     = count_q;
  assign underflow = underflow_q;
  assign dma_req   = dma_req_q;

endmodule

// File: tb/lcd_fifo_ram.sv
// tb/lcd_fifo_ram.sv - behavioural dual-port RAM with one-cycle synchronous read
module lcd_fifo_ram #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];

  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: tb/tb_lcd_dma_fifo.sv
// tb/tb_lcd_dma_fifo.sv - randomized bench for lcd_dma_fifo against a queue-based reference model
module tb_lcd_dma_fifo;
  import lcd_fifo_pkg::*;

  localparam int DW    = LCD_FIFO_DW;
  localparam int AW    = LCD_FIFO_AW;
  localparam int DEPTH = 1 << AW;

  logic          HCLK = 1'b0;
  logic          HRESET, flush, wr_valid, rd_req;
  logic [DW-1:0] wr_data;
  lcd_fifo_cnt_t watermark;
  logic          wr_ready, rd_valid, dma_req, underflow, mem_write;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  lcd_fifo_cnt_t count;
  logic [AW-1:0] mem_waddr, mem_raddr;

  lcd_dma_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .watermark(watermark), .dma_req(dma_req), .count(count), .underflow(underflow),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  lcd_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk(HCLK), .we(mem_write), .waddr(mem_waddr), .wdata(mem_wdata),
    .raddr(mem_raddr), .rdata(mem_rdata)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, pointers as running push/pop totals
  logic [DW-1:0] q[$];
  bit            m_uf, m_dma, m_valid;
  logic [DW-1:0] m_data;
  int            m_wr, m_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; applies one cycle of inputs and checks both phases
  task automatic cycle(input bit rst, input bit fl, input bit wv, input logic [DW-1:0] wd,
                       input bit rr, input int wm);
    int sz;
    bit push, pop;
    HRESET = rst; flush = fl; wr_valid = wv; wr_data = wd; rd_req = rr;
    watermark = lcd_fifo_cnt_t'(wm);
    #1;
    sz   = q.size();
    push = wv && (sz < DEPTH) && !fl;
    pop  = rr && (sz != 0) && !fl;
    if (!rst) begin
      check_eq("wr_ready", wr_ready, sz < DEPTH);
      check_eq("mem_write", mem_write, push);
      check_eq("mem_raddr", mem_raddr, m_rd % DEPTH);
      if (push) begin
        check_eq("mem_waddr", mem_waddr, m_wr % DEPTH);
        check_eq("mem_wdata", mem_wdata, wd);
      end
    end
    if (rst || fl) begin
      q.delete();
      m_uf = 0; m_dma = 0; m_valid = 0; m_wr = 0; m_rd = 0;
    end else begin
      if (sz == DEPTH) m_dma = 0;
      else if (sz <= wm) m_dma = 1;
      if (rr && sz == 0) m_uf = 1;
      m_valid = pop;
      if (pop) begin
        m_data = q.pop_front();
        m_rd++;
      end
      if (push) begin
        q.push_back(wd);
        m_wr++;
      end
    end
    @(posedge HCLK);
    #1;
    check_eq("count", count, q.size());
    check_eq("rd_valid", rd_valid, m_valid);
    if (m_valid) check_eq("rd_data", rd_data, m_data);
    check_eq("underflow", underflow, m_uf);
    check_eq("dma_req", dma_req, m_dma);
  endtask

  initial begin
    HRESET = 1; flush = 0; wr_valid = 0; wr_data = '0; rd_req = 0; watermark = 8;
    m_uf = 0; m_dma = 0; m_valid = 0; m_wr = 0; m_rd = 0; m_data = '0;
    @(posedge HCLK);
    #1;
    cycle(1, 0, 0, '0, 0, 8);
    check_eq("rst_wr_ready", wr_ready, 1);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_raddr", mem_raddr, 0);

    for (int i = 0; i < 32; i++) cycle(0, 0, 1, 32'h100 + i, 0, 8);
    check_eq("fill_count", count, 32);
    check_eq("fill_wr_ready", wr_ready, 0);
    cycle(0, 0, 0, '0, 0, 8);
    check_eq("fill_dma_low", dma_req, 0);

    for (int i = 0; i < 32; i++) cycle(0, 0, 0, '0, 1, 8);
    cycle(0, 0, 0, '0, 0, 8);
    check_eq("drain_count", count, 0);
    check_eq("drain_uf", underflow, 0);

    for (int i = 0; i < 8; i++) cycle(0, 0, 1, $urandom, 0, 8);
    for (int i = 0; i < 40; i++) cycle(0, 0, 1, $urandom, 1, 8);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, '0, 1, 8);
    cycle(0, 0, 0, '0, 0, 8);

    cycle(0, 0, 1, 32'hAA, 1, 8);
    check_eq("empty_both_count", count, 1);
    check_eq("empty_both_uf", underflow, 1);
    cycle(0, 0, 0, '0, 0, 8);
    check_eq("empty_both_rd_valid", rd_valid, 0);

    for (int i = 0; i < 19; i++) cycle(0, 0, 1, $urandom, 0, 8);
    check_eq("pre_flush_count", count, 20);
    cycle(0, 1, 1, 32'h55, 1, 8);
    check_eq("flush_count", count, 0);
    check_eq("flush_uf", underflow, 0);

    for (int i = 0; i < 17; i++) cycle(0, 0, 1, $urandom, 0, 20);
    check_eq("pre_rst_dma", dma_req, 1);
    cycle(1, 0, 1, $urandom, 1, 20);
    check_eq("post_rst_count", count, 0);
    check_eq("post_rst_wr_ready", wr_ready, 1);
    check_eq("post_rst_mem_raddr", mem_raddr, 0);

    for (int seg = 0; seg < 4; seg++) begin
      int pw;
      pw = (seg == 0) ? 80 : (seg == 1) ? 30 : 55;
      for (int i = 0; i < 500; i++) begin
        cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < 50,
              $urandom_range(0, 40));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
